event_readout_sequencer: RTL and testbench
==========================================

# event_readout_sequencer

Control FSM for one scintillator-triggered drift-tube readout cycle. It times the drift window after a coincidence, then walks the tube channels through the parent's mux and writes a header plus one tagged word per tube into the readout FIFO. It then pulses the tube/latch clear and re-arms. It replaces the free-running counter/case sequencing in the top level, adding FIFO back-pressure, dropped-event accounting and an event number.

## Interface
Parameters:
- WINDOW, 256: drift-window length in clk100 cycles (≥1)
- NTUBES, 32: number of tube channels scanned (1..256)
- CLR_CYCLES, 11: tube_clr pulse length in cycles (≥1)

Ports:
- clk100  in  1  system clock, 100 MHz; one clock domain only
- rst_n  in  1  asynchronous, active-low reset
- trig  in  1  latched coincidence level (SCIN latch Q), synchronous to clk100
- tube_sel  out  8  channel index presented to the parent's tube-data/tag mux
- tube_data  in  8  clock-cycle count of the selected tube (combinational from tube_sel)
- tube_tag  in  8  chamber/layer/wire tag of the selected tube (combinational from tube_sel)
- fifo_din  out  16  FIFO write data
- fifo_wr_en  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full flag, write-clock domain
- tube_clr  out  1  active-high clear to the tubes and SCIN latch
- busy  out  1  high whenever the state is not IDLE
- evt_cnt  out  16  completed-event counter, wraps at 2^16
- drop_cnt  out  16  dropped-event counter, saturates at 16'hFFFF

## Operation
- States: IDLE, WINDOW, HEADER, SCAN, CLEAR. State, window counter, index, evt_cnt and drop_cnt are registers.
- IDLE:
  - trig=1 and fifo_full=0 → WINDOW, window counter=0.
  - trig=1 and fifo_full=1 → CLEAR directly (event dropped); drop_cnt increments unless already saturated.
- WINDOW: the counter increments each cycle. After WINDOW cycles in this state → HEADER. trig is ignored.
- HEADER:
  - fifo_wr_en = !fifo_full; fifo_din = {8'hFF, evt_cnt[7:0]}.
  - Advance to SCAN with index=0 only on a cycle where a write occurs; otherwise hold.
- SCAN:
  - tube_sel = index; fifo_din = {tube_data, tube_tag}; fifo_wr_en = !fifo_full.
  - Index advances only on a write.
  - Write with index = NTUBES-1 → CLEAR; evt_cnt increments on this transition.
- CLEAR: tube_clr=1 for exactly CLR_CYCLES cycles → IDLE. There is no trig qualification on exit; a new coincidence can start on the first IDLE cycle.
- fifo_wr_en and fifo_din are combinational from registered state, index and fifo_full. A write is never issued while fifo_full=1, so the FIFO cannot overflow.
- tube_sel holds its last value outside SCAN and is 0 after reset.
- fifo_din = 16'h0000 when fifo_wr_en=0 in IDLE, WINDOW and CLEAR.

## Timing
- Reset values while rst_n=0: state IDLE, tube_sel=0, fifo_wr_en=0, fifo_din=0, busy=0, evt_cnt=0, drop_cnt=0. tube_clr=1 combinationally while rst_n=0, so the tubes are held cleared.
- Reset asserted mid-event aborts the event immediately. No further words are written, evt_cnt is not incremented, and a partial event may remain in the FIFO.
- Let cycle 0 be the edge at which IDLE samples trig=1. With no stalls:
  - WINDOW occupies cycles 1..WINDOW.
  - Header write occurs at cycle WINDOW+1.
  - Tube i is written at cycle WINDOW+2+i.
  - tube_clr is high for cycles WINDOW+NTUBES+2 .. WINDOW+NTUBES+CLR_CYCLES+1.
  - IDLE is reached at cycle WINDOW+NTUBES+CLR_CYCLES+2.
- Defaults: header at 257, tubes at 258..289, clear at 290..300, IDLE at 301.
- Each stall cycle (fifo_full=1 in HEADER or SCAN) delays all later events by one cycle.
- Drop path: tube_clr is high for cycles 1..CLR_CYCLES, then IDLE at cycle CLR_CYCLES+1; no FIFO writes occur.
- Exactly NTUBES+1 words are written per accepted event, in order: header, then tube 0 .. tube NTUBES-1.

## Test plan
- Reset, single trig, fifo_full=0, defaults → header 16'hFF00 at cycle 257; 32 words at cycles 258..289 each equal to {tube_data, tube_tag} for tube_sel 0..31; tube_clr at cycles 290..300; evt_cnt=1; busy low at cycle 301.
- Force fifo_full=1 for 5 cycles starting when tube_sel=10 → no write during those cycles, tube_sel holds at 10, the word sequence is unbroken; tube_clr starts 5 cycles later than nominal.
- Hold fifo_full=1 and pulse trig in IDLE → zero writes; tube_clr for 11 cycles; drop_cnt=1; evt_cnt unchanged.
- Drive rst_n low at cycle 270 of an event, then release → tube_clr high during reset, state IDLE, counters 0; the next trig produces a full 33-word event with header 16'hFF00.
- Run 257 back-to-back events with trig held high → headers cycle FF00..FFFF then FF00; evt_cnt=257 (16'h0101); each event starts at IDLE+0 with no idle gap.
- Parameters WINDOW=1, NTUBES=1, CLR_CYCLES=1 → header at cycle 2, tube word at cycle 3, tube_clr at cycle 4, IDLE at cycle 5.

Source files
------------

// File: rtl/event_readout_sequencer_if.sv
// Readout-side bundle of the event sequencer: tube mux select/data and FIFO write port.
// The sequencer drives it through the master modport; the parent mux and FIFO use slave.
interface event_readout_sequencer_if;
  logic [7:0]  tube_sel;
  logic [7:0]  tube_data;
  logic [7:0]  tube_tag;
  logic [15:0] fifo_din;
  logic        fifo_wr_en;
  logic        fifo_full;

  modport master (
    output tube_sel,
    output fifo_din,
    output fifo_wr_en,
    input  tube_data,
    input  tube_tag,
    input  fifo_full
  );

  modport slave (
    input  tube_sel,
    input  fifo_din,
    input  fifo_wr_en,
    output tube_data,
    output tube_tag,
    output fifo_full
  );
endinterface

// File: rtl/event_readout_sequencer.sv
// Drift-tube readout sequencer: after a coincidence it waits out the drift window,
// writes a header and one {data, tag} word per tube into the FIFO (stalling on full),
// pulses the tube/latch clear and re-arms. Events arriving while the FIFO is full are
// dropped straight to the clear phase and counted.
module event_readout_sequencer #(
  parameter int unsigned WINDOW     = 256,
  parameter int unsigned NTUBES     = 32,
  parameter int unsigned CLR_CYCLES = 11
) (
  input  logic                         clk100,
  input  logic                         rst_n,
  input  logic                         trig,
  event_readout_sequencer_if.master    bus,
  output logic                         tube_clr,
  output logic                         busy,
  output logic [15:0]                  evt_cnt,
  output logic [15:0]                  drop_cnt
);

  // One counter times both the drift window and the clear pulse.
  localparam int unsigned CntMax = (WINDOW > CLR_CYCLES) ? WINDOW : CLR_CYCLES;
  localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;
  localparam logic [CntW-1:0] WinLast = CntW'(WINDOW - 1);
  localparam logic [CntW-1:0] ClrLast = CntW'(CLR_CYCLES - 1);
  localparam logic [7:0]      IdxLast = 8'(NTUBES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StWindow,
    StHeader,
    StScan,
    StClear
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [7:0]      idx_q;
  logic [15:0]     evt_q;
  logic [15:0]     drop_q;
  logic            wr_en;

  // FIFO write port: only HEADER and SCAN write, and never into a full FIFO.
  always_comb begin
    wr_en        = 1'b0;
    bus.fifo_din = 16'h0000;
    case (state_q)
      StHeader: begin
        wr_en        = !bus.fifo_full;
        bus.fifo_din = {8'hFF, evt_q[7:0]};
      end
      StScan: begin
        wr_en        = !bus.fifo_full;
        bus.fifo_din = {bus.tube_data, bus.tube_tag};
      end
      default: ;
    endcase
  end

  assign bus.fifo_wr_en = wr_en;
  assign bus.tube_sel   = idx_q;
  // Clear is forced while in reset so the tubes stay cleared.
  assign tube_clr       = !rst_n || (state_q == StClear);
  assign busy           = (state_q != StIdle);
  assign evt_cnt        = evt_q;
  assign drop_cnt       = drop_q;

  // Sequencer FSM with its window/clear counter, tube index and event counters.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= 8'd0;
      evt_q   <= 16'd0;
      drop_q  <= 16'd0;
    end else begin
      case (state_q)
        StIdle: begin
          if (trig) begin
            cnt_q <= '0;
            if (!bus.fifo_full) begin
              state_q <= StWindow;
            end else begin
              state_q <= StClear;
              if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
            end
          end
        end
        StWindow: begin
          if (cnt_q == WinLast) state_q <= StHeader;
          else                  cnt_q   <= cnt_q + 1'b1;
        end
        StHeader: begin
          if (wr_en) begin
            state_q <= StScan;
            idx_q   <= 8'd0;
          end
        end
        StScan: begin
          if (wr_en) begin
            if (idx_q == IdxLast) begin
              state_q <= StClear;
              cnt_q   <= '0;
              evt_q   <= evt_q + 16'd1;
            end else begin
              idx_q <= idx_q + 8'd1;
            end
          end
        end
        StClear: begin
          if (cnt_q == ClrLast) state_q <= StIdle;
          else                  cnt_q   <= cnt_q + 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_event_readout_sequencer.sv
// Bench for event_readout_sequencer: directed events with hand-computed word timing.
// Stimulus pushes expected {cycle, word} into per-DUT queues; monitors pop on each write.
module tb_event_readout_sequencer;
  localparam int W = 256;
  localparam int N = 32;
  localparam int C = 11;

  typedef struct {
    int          cyc;
    logic [15:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic trig = 1'b0;
  logic trig2 = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  exp_t q1[$];
  exp_t q2[$];
  exp_t e1;
  exp_t e2;

  logic        clr1, busy1, clr2, busy2;
  logic [15:0] evt1, drop1, evt2, drop2;

  event_readout_sequencer_if bus1 ();
  event_readout_sequencer_if bus2 ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Parent mux model: data and tag are simple functions of the selected channel.
  assign bus1.tube_data = bus1.tube_sel * 8'd3 + 8'd7;
  assign bus1.tube_tag  = bus1.tube_sel ^ 8'hA5;
  assign bus2.tube_data = bus2.tube_sel * 8'd3 + 8'd7;
  assign bus2.tube_tag  = bus2.tube_sel ^ 8'hA5;

  event_readout_sequencer dut (
    .clk100   (clk),
    .rst_n    (rst_n),
    .trig     (trig),
    .bus      (bus1),
    .tube_clr (clr1),
    .busy     (busy1),
    .evt_cnt  (evt1),
    .drop_cnt (drop1)
  );

  event_readout_sequencer #(
    .WINDOW     (1),
    .NTUBES     (1),
    .CLR_CYCLES (1)
  ) dut_small (
    .clk100   (clk),
    .rst_n    (rst_n),
    .trig     (trig2),
    .bus      (bus2),
    .tube_clr (clr2),
    .busy     (busy2),
    .evt_cnt  (evt2),
    .drop_cnt (drop2)
  );

  function automatic logic [15:0] word(input int i);
    logic [7:0] s;
    s = 8'(i);
    return {s * 8'd3 + 8'd7, s ^ 8'hA5};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Returns in period k (after edge k-1), 1 ns past the edge: inputs set here hit edge k.
  task automatic drive_at(input int k);
    while (cyc < k - 1) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Returns at the falling edge inside period k (the period ending at edge k).
  task automatic at_period(input int k);
    drive_at(k);
    @(negedge clk);
  endtask

  // Expected words of an accepted default-size event sampled at edge t0.
  task automatic push_event(input int t0, input logic [7:0] hb, input int nt,
                            input int sidx, input int slen);
    exp_t e;
    e.cyc  = t0 + W + 1;
    e.data = {8'hFF, hb};
    q1.push_back(e);
    for (int i = 0; i < nt; i++) begin
      e.cyc  = t0 + W + 2 + i + ((i >= sidx) ? slen : 0);
      e.data = word(i);
      q1.push_back(e);
    end
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_tube_clr"}, clr1, 1);
    check({tag, "_busy"}, busy1, 0);
    check({tag, "_wr_en"}, bus1.fifo_wr_en, 0);
    check({tag, "_din"}, bus1.fifo_din, 0);
    check({tag, "_evt_cnt"}, evt1, 0);
    check({tag, "_drop_cnt"}, drop1, 0);
    check({tag, "_tube_sel"}, bus1.tube_sel, 0);
  endtask

  // Monitor for the default DUT: every write must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus1.fifo_full) check("no_write_when_full", bus1.fifo_wr_en, 0);
      if (bus1.fifo_wr_en) begin
        if (q1.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got %0h at cycle %0d, expected no write",
                   bus1.fifo_din, cyc + 1);
        end else begin
          e1 = q1.pop_front();
          check("word_data", bus1.fifo_din, e1.data);
          check("word_cycle", cyc + 1, e1.cyc);
        end
      end
    end
  end

  // Monitor for the minimum-parameter DUT.
  always @(negedge clk) begin
    if (rst_n && bus2.fifo_wr_en) begin
      if (q2.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL small_unexpected_write: got %0h at cycle %0d, expected no write",
                 bus2.fifo_din, cyc + 1);
      end else begin
        e2 = q2.pop_front();
        check("small_word_data", bus2.fifo_din, e2.data);
        check("small_word_cycle", cyc + 1, e2.cyc);
      end
    end
  end

  initial begin
    int t;
    exp_t e;
    bus1.fifo_full = 1'b0;
    bus2.fifo_full = 1'b0;

    // Reset state
    at_period(2);
    reset_checks("reset");
    drive_at(4);
    rst_n = 1'b1;

    // Minimum parameters: header at 2, tube at 3, clear at 4, idle at 5
    t = 10;
    e.cyc = t + 2; e.data = 16'hFF00; q2.push_back(e);
    e.cyc = t + 3; e.data = word(0);  q2.push_back(e);
    drive_at(t);     trig2 = 1'b1;
    drive_at(t + 1); trig2 = 1'b0;
    at_period(t + 3);
    check("small_clr_before", clr2, 0);
    check("small_busy_scan", busy2, 1);
    at_period(t + 4);
    check("small_clr", clr2, 1);
    at_period(t + 5);
    check("small_clr_after", clr2, 0);
    check("small_idle", busy2, 0);
    check("small_evt_cnt", evt2, 1);

    // Single nominal event
    t = 20;
    push_event(t, 8'h00, N, N, 0);
    drive_at(t);     trig = 1'b1;
    drive_at(t + 1); trig = 1'b0;
    at_period(t + 1);
    check("ev1_busy", busy1, 1);
    at_period(t + W + N + 1);
    check("ev1_clr_before", clr1, 0);
    at_period(t + W + N + 2);
    check("ev1_clr_first", clr1, 1);
    check("ev1_evt_cnt", evt1, 1);
    at_period(t + W + N + C + 1);
    check("ev1_clr_last", clr1, 1);
    at_period(t + W + N + C + 2);
    check("ev1_clr_after", clr1, 0);
    check("ev1_idle", busy1, 0);
    check("ev1_queue_empty", q1.size(), 0);

    // Five-cycle FIFO stall while tube 10 is selected
    t = 326;
    push_event(t, 8'h01, N, 10, 5);
    drive_at(t);     trig = 1'b1;
    drive_at(t + 1); trig = 1'b0;
    drive_at(t + 268); bus1.fifo_full = 1'b1;
    at_period(t + 268);
    check("stall_sel_start", bus1.tube_sel, 10);
    at_period(t + 272);
    check("stall_sel_end", bus1.tube_sel, 10);
    drive_at(t + 273); bus1.fifo_full = 1'b0;
    at_period(t + 294);
    check("stall_clr_before", clr1, 0);
    at_period(t + 295);
    check("stall_clr_first", clr1, 1);
    at_period(t + 305);
    check("stall_clr_last", clr1, 1);
    at_period(t + 306);
    check("stall_clr_after", clr1, 0);
    check("stall_idle", busy1, 0);
    check("stall_evt_cnt", evt1, 2);

    // Dropped event: FIFO full when the trigger arrives
    t = 636;
    drive_at(t);     bus1.fifo_full = 1'b1; trig = 1'b1;
    drive_at(t + 1); trig = 1'b0;
    at_period(t + 1);
    check("drop_clr_first", clr1, 1);
    check("drop_busy", busy1, 1);
    at_period(t + C);
    check("drop_clr_last", clr1, 1);
    at_period(t + C + 1);
    check("drop_clr_after", clr1, 0);
    check("drop_idle", busy1, 0);
    check("drop_cnt", drop1, 1);
    check("drop_evt_unchanged", evt1, 2);
    drive_at(t + C + 2); bus1.fifo_full = 1'b0;

    // Reset mid-event at cycle 270: header and tubes 0..11 were already written
    t = 656;
    push_event(t, 8'h02, 12, N, 0);
    drive_at(t);       trig = 1'b1;
    drive_at(t + 1);   trig = 1'b0;
    drive_at(t + 270); rst_n = 1'b0;
    at_period(t + 270);
    reset_checks("midrst");
    check("midrst_queue_empty", q1.size(), 0);
    drive_at(t + 273); rst_n = 1'b1;
    t = t + 280;
    push_event(t, 8'h00, N, N, 0);
    drive_at(t);     trig = 1'b1;
    drive_at(t + 1); trig = 1'b0;
    at_period(t + W + N + C + 2);
    check("postrst_idle", busy1, 0);
    check("postrst_evt_cnt", evt1, 1);
    check("postrst_queue_empty", q1.size(), 0);

    // 257 back-to-back events with trig held high; header byte wraps to 00
    drive_at(t + 305); rst_n = 1'b0;
    drive_at(t + 307); rst_n = 1'b1;
    t = t + 310;
    for (int ev = 0; ev < 257; ev++) push_event(t + 301 * ev, 8'(ev), N, N, 0);
    drive_at(t); trig = 1'b1;
    at_period(t + 301);
    check("b2b_idle_gap", busy1, 0);
    at_period(t + 302);
    check("b2b_restart", busy1, 1);
    drive_at(t + 301 * 256 + 1); trig = 1'b0;
    at_period(t + 301 * 257);
    check("b2b_idle_end", busy1, 0);
    check("b2b_evt_cnt", evt1, 16'h0101);
    check("b2b_drop_cnt", drop1, 0);
    check("final_queue_empty", q1.size(), 0);
    check("final_small_queue_empty", q2.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
